// File: rtl/pwm_capture_if.sv
// rtl/pwm_capture_if.sv - PWM capture signal bundle: sampled input and measurement report
interface pwm_capture_if #(
    parameter int CNT_W = 9
);
    logic             pwm_i;
    logic [CNT_W-1:0] high_o;
    logic [CNT_W-1:0] period_o;
    logic             valid_o;
    logic             stuck_o;

    modport master (
        output pwm_i,
        input  high_o,
        input  period_o,
        input  valid_o,
        input  stuck_o
    );

    modport slave (
        input  pwm_i,
        output high_o,
        output period_o,
        output valid_o,
        output stuck_o
    );
endinterface

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - PWM high-time/period capture with stuck timeout; PWM_CAP_GLITCH_EN adds a 3-sample majority filter
module pwm_capture #(
    parameter int CNT_W = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    pwm_capture_if.slave cap
);
    localparam logic [CNT_W-1:0] MAX = '1;
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] MEAS  = 2'd1;
    localparam logic [1:0] STUCK = 2'd2;

    logic [1:0]       state;
    logic             s1, s2, prv;
    logic             sig;
    logic             rise;
    logic             timeout;
    logic [CNT_W-1:0] per_cnt, hi_cnt;
    logic [CNT_W-1:0] per_inc, hi_inc;
    logic [CNT_W-1:0] high_r, period_r;
    logic             valid_r, stuck_r;

    // Sync and edge flops reset high so a line already high at release is not a rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1  <= 1'b1;
            s2  <= 1'b1;
            prv <= 1'b1;
        end else begin
            s1  <= cap.pwm_i;
            s2  <= s1;
            prv <= sig;
        end
    end

`ifdef PWM_CAP_GLITCH_EN
    logic d1, d2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d1 <= 1'b1;
            d2 <= 1'b1;
        end else begin
            d1 <= s2;
            d2 <= d1;
        end
    end

    assign sig = (s2 & d1) | (s2 & d2) | (d1 & d2);
`else
    assign sig = s2;
`endif

    assign rise    = sig & ~prv;
    assign timeout = (per_cnt == MAX);
    assign per_inc = timeout ? MAX : per_cnt + ONE;
    assign hi_inc  = (sig && hi_cnt != MAX) ? hi_cnt + ONE : hi_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            per_cnt  <= '0;
            hi_cnt   <= '0;
            high_r   <= '0;
            period_r <= '0;
            valid_r  <= 1'b0;
            stuck_r  <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            case (state)
                IDLE: begin
                    // The window started by reset is incomplete, so its first rise is not reported.
                    if (rise) begin
                        state   <= MEAS;
                        per_cnt <= ONE;
                        hi_cnt  <= ONE;
                    end else if (timeout) begin
                        state    <= STUCK;
                        period_r <= '0;
                        high_r   <= sig ? MAX : '0;
                        stuck_r  <= 1'b1;
                        valid_r  <= 1'b1;
                    end else begin
                        per_cnt <= per_inc;
                    end
                end
                MEAS: begin
                    if (rise) begin
                        period_r <= per_cnt;
                        high_r   <= hi_cnt;
                        stuck_r  <= 1'b0;
                        valid_r  <= 1'b1;
                        per_cnt  <= ONE;
                        hi_cnt   <= ONE;
                    end else if (timeout) begin
                        state    <= STUCK;
                        period_r <= '0;
                        high_r   <= sig ? MAX : '0;
                        stuck_r  <= 1'b1;
                        valid_r  <= 1'b1;
                    end else begin
                        per_cnt <= per_inc;
                        hi_cnt  <= hi_inc;
                    end
                end
                STUCK: begin
                    if (rise) begin
                        state   <= MEAS;
                        per_cnt <= ONE;
                        hi_cnt  <= ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign cap.high_o   = high_r;
    assign cap.period_o = period_r;
    assign cap.valid_o  = valid_r;
    assign cap.stuck_o  = stuck_r;
endmodule
